tbi_rx_aligner: RTL
===================

TBI_RX_ALIGNER -- requirements
Module: tbi_rx_aligner

Interface
REQ-001 Parameter g_commas_to_sync, default 3: commas at one offset needed to declare sync.
REQ-002 Parameter g_bad_to_loss, default 4: invalid-code count that drops sync.
REQ-003 Parameter g_good_to_recover, default 4: consecutive valid codes that decrement the invalid count by one.
REQ-004 clk_sys_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 rx_data_i  in  10  raw TBI code group from the loopback FIFO, one per clock.
REQ-007 rx_data_o  out  10  realigned code group.
REQ-008 rx_valid_o  out  1  high when rx_data_o is a code group aligned while synced.
REQ-009 rx_comma_o  out  1  rx_data_o is a comma (K28.5 prefix).
REQ-010 code_err_o  out  1  rx_data_o failed the validity check.
REQ-011 synced_o  out  1  sync FSM is in SYNC_ACQUIRED.
REQ-012 offset_o  out  4  current alignment offset, 0..9.
REQ-013 err_cnt_o  out  16  saturating count of invalid codes seen while synced.

Function
REQ-014 Window w = {previous rx_data_i, current rx_data_i}, 20 bits; candidate k (0..9) = w[19-k -: 10].
REQ-015 Candidate is a comma iff bits [9:3] equal 7'b0011111 or 7'b1100000.
REQ-016 Code valid iff popcount is 4, 5 or 6; 10'h3FF and 10'h000 are therefore invalid.
REQ-017 Comma search takes the lowest-index comma candidate; ties are not possible between different offsets in the same cycle.
REQ-018 Output latency: rx_data_o/flags correspond to rx_data_i from exactly 2 cycles earlier, using offset_o.
REQ-019 FSM states: LOSS_OF_SYNC, COMMA_DETECT, SYNC_ACQUIRED.
REQ-020 LOSS_OF_SYNC: on any comma at offset k, latch offset_o = k, comma count = 1, go to COMMA_DETECT.
REQ-021 COMMA_DETECT: invalid code at offset -> LOSS_OF_SYNC; comma at offset -> count+1; count reaching g_commas_to_sync -> SYNC_ACQUIRED, bad=0, good=0.
REQ-022 COMMA_DETECT: comma at a different offset -> relatch offset, count = 1, stay.
REQ-023 SYNC_ACQUIRED: invalid code or comma at a different offset -> bad+1, good=0, err_cnt_o+1 (saturate at 16'hFFFF).
REQ-024 SYNC_ACQUIRED: valid code -> good+1; good reaching g_good_to_recover with bad>0 -> bad-1, good=0.
REQ-025 SYNC_ACQUIRED: bad reaching g_bad_to_loss -> LOSS_OF_SYNC next cycle; offset_o held.
REQ-026 Invalid and valid event in one cycle impossible; invalid takes precedence over comma for counting.
REQ-027 rx_valid_o low in LOSS_OF_SYNC and COMMA_DETECT; rx_data_o still driven.

Reset
REQ-028 On rst_i high: state LOSS_OF_SYNC, window/pipeline zero, all outputs 0, err_cnt_o 0.
REQ-029 Reset asserted mid-operation takes effect immediately (asynchronous); first comma search after release needs one fresh previous word.

Structure
REQ-030 Shared package tbi_pkg holds FSM state enum, K28.5 comma prefix constants and code-width constant 10.
REQ-031 One sub-module tbi_comma_detect: combinational 20-bit window scan returning hit flag and offset.
REQ-032 Popcount validity check is a package function.

Verification
REQ-033 Repeating K28.5+D16.2 (10'b0011111010, 10'b1001000101) at offset 0 -> synced_o high after 3rd comma, offset_o=0, err_cnt_o=0.
REQ-034 Same stream delayed by 3 bits across words -> lock with offset_o=3, rx_data_o reproduces original codes.
REQ-035 While synced, inject 4 consecutive 10'h3FF -> synced_o low one cycle after 4th, err_cnt_o=4.
REQ-036 While synced, 3 bad codes each followed by 4 good -> sync retained, bad returns to 0.
REQ-037 Invalid code in COMMA_DETECT after 2 commas -> LOSS_OF_SYNC, relock needs 3 new commas.
REQ-038 rst_i pulse while synced -> all outputs 0 same cycle, relock from LOSS_OF_SYNC.

Source files
------------

// File: rtl/tbi_pkg.sv
// Shared definitions for the TBI receive aligner: code width, comma
// prefixes, sync FSM states and the code-group helper functions.
package tbi_pkg;

  localparam int CODE_W = 10;
  localparam int WIN_W  = 2 * CODE_W;

  // K28.5 comma prefixes (bits [9:3]) for both running disparities.
  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT,
    SYNC_ACQUIRED
  } sync_state_t;

  // A code group is plausible 8b/10b only if its popcount is 4, 5 or 6.
  function automatic logic code_valid(input logic [CODE_W-1:0] code);
    int ones;
    ones = 0;
    for (int i = 0; i < CODE_W; i++) ones += int'(code[i]);
    return (ones >= 4) && (ones <= 6);
  endfunction

  function automatic logic is_comma(input logic [CODE_W-1:0] code);
    return (code[9:3] == COMMA_POS) || (code[9:3] == COMMA_NEG);
  endfunction

endpackage

// File: rtl/tbi_comma_detect.sv
// Combinational comma search over a 20-bit window of two received words.
// Candidate k is window[19-k -: 10]; the lowest-index comma wins.
module tbi_comma_detect
  import tbi_pkg::*;
(
  input  logic [WIN_W-1:0] window,
  output logic             hit,
  output logic [3:0]       offset
);

  // Scan from the highest index down so the lowest-index comma is left last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    hit    = 1'b0;
    offset = '0;
    for (int k = CODE_W - 1; k >= 0; k--) begin
      if (is_comma(window[WIN_W-1-k -: CODE_W])) begin
        hit    = 1'b1;
        offset = 4'(k);
      end
    end
  end

endmodule

// File: rtl/tbi_rx_aligner.sv
// TBI receive word aligner: finds K28.5 commas in the raw 10-bit stream,
// locks an alignment offset, and tracks code validity to hold or drop sync.
module tbi_rx_aligner
  import tbi_pkg::*;
#(
  parameter int g_commas_to_sync  = 3,
  parameter int g_bad_to_loss     = 4,
  parameter int g_good_to_recover = 4
) (
  input  logic              clk_sys_i,
  input  logic              rst_i,
  input  logic [CODE_W-1:0] rx_data_i,
  output logic [CODE_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_comma_o,
  output logic              code_err_o,
  output logic              synced_o,
  output logic [3:0]        offset_o,
  output logic [15:0]       err_cnt_o
);

  localparam logic [7:0] CNT_SYNC = 8'(g_commas_to_sync);
  localparam logic [7:0] CNT_LOSS = 8'(g_bad_to_loss);
  localparam logic [7:0] CNT_GOOD = 8'(g_good_to_recover);

  logic [CODE_W-1:0] prev_word;
  logic              primed;      // a real previous word has been captured since reset
  logic [WIN_W-1:0]  window;
  logic [CODE_W-1:0] cand;
  logic              hit_raw, hit;
  logic [3:0]        hit_offset;
  logic              cand_valid, cand_comma, other_comma;

  sync_state_t state_q, state_d;
  logic [3:0]  offset_d;
  logic [7:0]  comma_cnt_q, comma_cnt_d;
  logic [7:0]  bad_q, bad_d;
  logic [7:0]  good_q, good_d;
  logic [15:0] err_cnt_d;

  assign window = {prev_word, rx_data_i};

  tbi_comma_detect u_comma_detect (
    .window (window),
    .hit    (hit_raw),
    .offset (hit_offset)
  );

  // The zero word left by reset is not real data, so no search until primed.
  assign hit         = hit_raw & primed;
  assign cand_valid  = code_valid(cand);
  assign cand_comma  = is_comma(cand);
  assign other_comma = hit && (hit_offset != offset_o);
  assign synced_o    = (state_q == SYNC_ACQUIRED);

  // Extract the code group sitting at the current alignment offset.
  always_comb begin
    cand = window[WIN_W-1 -: CODE_W];
    for (int k = 1; k < CODE_W; k++) begin
      if (offset_o == 4'(k)) cand = window[WIN_W-1-k -: CODE_W];
    end
  end

  // Sync FSM next state and counter updates.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_o;
    comma_cnt_d = comma_cnt_q;
    bad_d       = bad_q;
    good_d      = good_q;
    err_cnt_d   = err_cnt_o;
    unique case (state_q)
      LOSS_OF_SYNC: begin
        if (hit) begin
          offset_d    = hit_offset;
          comma_cnt_d = 8'd1;
          state_d     = COMMA_DETECT;
        end
      end
      COMMA_DETECT: begin
        if (!cand_valid) begin
          state_d = LOSS_OF_SYNC;
        end else if (cand_comma) begin
          comma_cnt_d = comma_cnt_q + 8'd1;
          if (comma_cnt_d == CNT_SYNC) begin
            state_d = SYNC_ACQUIRED;
            bad_d   = '0;
            good_d  = '0;
          end
        end else if (other_comma) begin
          offset_d    = hit_offset;
          comma_cnt_d = 8'd1;
        end
      end
      SYNC_ACQUIRED: begin
        if (!cand_valid || other_comma) begin
          bad_d  = bad_q + 8'd1;
          good_d = '0;
          if (err_cnt_o != 16'hFFFF) err_cnt_d = err_cnt_o + 16'd1;
          if (bad_d == CNT_LOSS) state_d = LOSS_OF_SYNC;
        end else begin
          good_d = good_q + 8'd1;
          if (good_d == CNT_GOOD) begin
            good_d = '0;
            if (bad_q != 8'd0) bad_d = bad_q - 8'd1;
          end
        end
      end
      default: state_d = LOSS_OF_SYNC;
    endcase
  end

  // Sync FSM state, offset and counter registers.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= LOSS_OF_SYNC;
      offset_o    <= '0;
      comma_cnt_q <= '0;
      bad_q       <= '0;
      good_q      <= '0;
      err_cnt_o   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= state_d;
      offset_o    <= offset_d;
      comma_cnt_q <= comma_cnt_d;
      bad_q       <= bad_d;
      good_q      <= good_d;
      err_cnt_o   <= err_cnt_d;
    end
  end

  // Previous-word register and registered aligned output with its flags.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      prev_word  <= '0;
      primed     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_comma_o <= 1'b0;
      code_err_o <= 1'b0;
    end else begin
      prev_word  <= rx_data_i;
      primed     <= 1'b1;
      rx_data_o  <= cand;
      rx_valid_o <= (state_q == SYNC_ACQUIRED);
      rx_comma_o <= cand_comma;
      code_err_o <= !cand_valid;
    end
  end

endmodule
